// File: rtl/ysyx_22040237_multi_cyc_ctrl_pkg.sv
// Shared types and constants for the multi-cycle sequencer: state encoding,
// halt codes, the NOP instruction and the default reset PC.
package ysyx_22040237_multi_cyc_ctrl_pkg;

   typedef enum logic [2:0] {
      IF_REQ,
      IF_WAIT,
      EX,
      MEM_REQ,
      MEM_WAIT,
      WB,
      HALT
   } state_t;

   localparam logic [1:0] HALT_NONE    = 2'd0;
   localparam logic [1:0] HALT_EBREAK  = 2'd1;
   localparam logic [1:0] HALT_INVALID = 2'd2;
   localparam logic [1:0] HALT_BUS_ERR = 2'd3;

   localparam logic [31:0] INST_NOP         = 32'h0000_0013;
   localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

endpackage

// File: rtl/ysyx_22040237_perf_cnt.sv
// Free-running cycle and retired-instruction counters, both wrapping at 2^64.
module ysyx_22040237_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_cyc_en,
   input  logic        i_inst_en,
   output logic [63:0] o_cyc_cnt,
   output logic [63:0] o_inst_cnt
);

   logic [63:0] r_cyc_cnt;
   logic [63:0] r_inst_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cyc_cnt  <= '0;
         r_inst_cnt <= '0;
      end else begin
         if (i_cyc_en)  r_cyc_cnt  <= r_cyc_cnt + 64'd1;
         if (i_inst_en) r_inst_cnt <= r_inst_cnt + 64'd1;
      end
   end

   assign o_cyc_cnt  = r_cyc_cnt;
   assign o_inst_cnt = r_inst_cnt;

endmodule

// File: rtl/ysyx_22040237_multi_cyc_ctrl.sv
// Multi-cycle fetch/execute/memory/write-back sequencer for the RV64 core.
// Define YSYX_22040237_PERF_CNT_EN to add the cyc_cnt/inst_cnt counters.
module ysyx_22040237_multi_cyc_ctrl
   import ysyx_22040237_multi_cyc_ctrl_pkg::*;
#(
   parameter int unsigned XLEN     = 64,
   parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_inst,
   input  logic            imem_rsp_err,
   output logic [31:0]     inst_o,
   input  logic            dec_ebreak,
   input  logic            dec_invalid,
   input  logic            dec_is_load,
   input  logic            dec_is_store,
   input  logic            jump_flag,
   input  logic [XLEN-1:0] pc_jump_addr,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   input  logic            dmem_rsp_valid,
   input  logic            rd_w_en_i,
   output logic            rd_w_en_o,
   output logic [XLEN-1:0] pc,
   output logic            retire,
   output logic            halted,
   output logic [1:0]      halt_code
`ifdef YSYX_22040237_PERF_CNT_EN
   ,
   output logic [63:0]     cyc_cnt,
   output logic [63:0]     inst_cnt
`endif
);

   state_t          r_state, w_state_nxt;
   logic [XLEN-1:0] r_pc, w_pc_nxt;
   logic [31:0]     r_inst, w_inst_nxt;
   logic [1:0]      r_halt_code, w_halt_code_nxt;
   logic            r_run;
   logic            w_ebreak_retire;
   logic            w_jump_misaligned;
   logic [XLEN-1:0] w_pc_seq;
   logic [XLEN-1:0] w_pc_tgt;

   assign w_pc_seq          = r_pc + XLEN'(4);
   assign w_pc_tgt          = pc_jump_addr & ~XLEN'(1);
   assign w_jump_misaligned = jump_flag & pc_jump_addr[1];

   // r_run keeps the fetch request low in the first cycle out of reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IF_REQ;
         r_pc        <= RESET_PC[XLEN-1:0];
         r_inst      <= INST_NOP;
         r_halt_code <= HALT_NONE;
         r_run       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_pc        <= w_pc_nxt;
         r_inst      <= w_inst_nxt;
         r_halt_code <= w_halt_code_nxt;
         r_run       <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pc_nxt        = r_pc;
      w_inst_nxt      = r_inst;
      w_halt_code_nxt = r_halt_code;
      w_ebreak_retire = 1'b0;
      case (r_state)
         IF_REQ: begin
            if (r_run && imem_req_ready) w_state_nxt = IF_WAIT;
         end
         IF_WAIT: begin
            if (imem_rsp_valid) begin
               if (imem_rsp_err) begin
                  w_state_nxt     = HALT;
                  w_halt_code_nxt = HALT_BUS_ERR;
               end else begin
                  w_inst_nxt  = imem_rsp_inst;
                  w_state_nxt = EX;
               end
            end
         end
         EX: begin
            if (dec_invalid || w_jump_misaligned) begin
               w_state_nxt     = HALT;
               w_halt_code_nxt = HALT_INVALID;
            end else if (dec_ebreak) begin
               w_ebreak_retire = 1'b1;
               w_state_nxt     = HALT;
               w_halt_code_nxt = HALT_EBREAK;
            end else if (dec_is_load || dec_is_store) begin
               w_state_nxt = MEM_REQ;
            end else begin
               w_state_nxt = WB;
            end
         end
         MEM_REQ: begin
            if (dmem_req_ready) w_state_nxt = MEM_WAIT;
         end
         MEM_WAIT: begin
            if (dmem_rsp_valid) w_state_nxt = WB;
         end
         WB: begin
            w_pc_nxt    = jump_flag ? w_pc_tgt : w_pc_seq;
            w_state_nxt = IF_REQ;
         end
         HALT: ;
         default: w_state_nxt = IF_REQ;
      endcase
   end

   assign imem_req_valid = (r_state == IF_REQ) && r_run;
   assign imem_addr      = r_pc;
   assign dmem_req_valid = (r_state == MEM_REQ);
   assign inst_o         = r_inst;
   assign rd_w_en_o      = (r_state == WB) && rd_w_en_i;
   assign retire         = (r_state == WB) || w_ebreak_retire;
   assign pc             = r_pc;
   assign halted         = (r_state == HALT);
   assign halt_code      = r_halt_code;

`ifdef YSYX_22040237_PERF_CNT_EN
   ysyx_22040237_perf_cnt u_perf_cnt (
      .clk        (clk),
      .rst        (rst),
      .i_cyc_en   (r_state != HALT),
      .i_inst_en  (retire),
      .o_cyc_cnt  (cyc_cnt),
      .o_inst_cnt (inst_cnt)
   );
`endif

endmodule
